onehot_decoder_seq: RTL and testbench

- Sequenced 3-to-8 one-hot decoder. It is the decode-side counterpart of the team's 8-to-3 one-hot encoder.
- Accepts a binary code over a valid/ready handshake.
- Drives the matching one-hot strobe on a registered output for HOLD clock cycles, then releases it.
- Sits between control logic that produces select codes and downstream one-hot enable/select lines, for example mux selects or per-lane strobes.

---
 rtl/onehot_decoder_seq_pkg.sv | 27 ++
 rtl/onehot_dec_comb.sv | 16 +
 rtl/onehot_decoder_seq.sv | 118 +++++++++++
 tb/tb_onehot_decoder_seq.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/onehot_decoder_seq_pkg.sv
// Shared types, default sizes and helpers for the one-hot decoder/encoder pair.
package onehot_decoder_seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_e;

    // Minimum counter width is 1 so that HOLD = 1 still has a real register.
    function automatic int cnt_width(input int hold);
        return (hold > 1) ? $clog2(hold) : 1;
    endfunction

    localparam int CODE_W_DEF = 3;
    localparam int HOLD_DEF   = 4;
    localparam int N          = 2 ** CODE_W_DEF;
    localparam int CNT_W      = cnt_width(HOLD_DEF);

    // Reference decode at the default width, also used by the encoder bench.
    function automatic logic [N-1:0] onehot_of(input logic [CODE_W_DEF-1:0] code);
        logic [N-1:0] r;
        r       = '0;
        r[code] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/onehot_dec_comb.sv
// Pure combinational N-way binary to one-hot decode.
module onehot_dec_comb #(
    parameter int CODE_W = 3
) (
    input  logic [CODE_W-1:0]      code,
    output logic [(2**CODE_W)-1:0] onehot
);

    localparam int OUT_W = 2 ** CODE_W;

    // Every code value is legal, so the shift always yields exactly one set bit.
    always_comb begin
        onehot = {{(OUT_W-1){1'b0}}, 1'b1} << code;
    end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Sequenced one-hot decoder: accepts a code over valid/ready and holds the
// matching one-hot strobe for HOLD cycles on registered outputs.
module onehot_decoder_seq
    import onehot_decoder_seq_pkg::*;
#(
    parameter int CODE_W = 3,
    parameter int HOLD   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CODE_W-1:0]       in_code,
    output logic [(2**CODE_W)-1:0]  out_onehot,
    output logic                    out_valid,
    output logic                    out_last,
    output logic [CODE_W-1:0]       out_code
);

    localparam int OUT_W = 2 ** CODE_W;
    localparam int CW    = cnt_width(HOLD);
    localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

    generate
        if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
            $error("onehot_decoder_seq: HOLD must be in 1..255");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [OUT_W-1:0]   onehot_q, onehot_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic               valid_q, valid_d;
    logic [OUT_W-1:0]   dec_onehot;
    logic               at_last;
    logic               transfer;

    onehot_dec_comb #(.CODE_W(CODE_W)) u_dec (
        .code   (in_code),
        .onehot (dec_onehot)
    );

    // Ready depends only on state (and is forced low while reset is held).
    always_comb begin
        at_last  = (state_q == DRIVE) && (cnt_q == LAST);
        in_ready = rst_n && ((state_q == IDLE) || at_last);
        transfer = in_valid && in_ready;
    end

    // Next-state logic: load on transfer, count while driving, clear when done.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        onehot_d = onehot_q;
        code_d   = code_q;
        valid_d  = valid_q;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    state_d  = DRIVE;
                    onehot_d = dec_onehot;
                    code_d   = in_code;
                    cnt_d    = '0;
                    valid_d  = 1'b1;
                end
            end
            DRIVE: begin
                if (cnt_q != LAST) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (transfer) begin
                    onehot_d = dec_onehot;
                    code_d   = in_code;
                    cnt_d    = '0;
                end else begin
                    state_d  = IDLE;
                    onehot_d = '0;
                    code_d   = '0;
                    cnt_d    = '0;
                    valid_d  = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                onehot_d = '0;
                code_d   = '0;
                cnt_d    = '0;
                valid_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            onehot_q <= '0;
            code_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            onehot_q <= onehot_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
        end
    end

    // Registered outputs; out_last marks the final cycle of each strobe.
    always_comb begin
        out_onehot = onehot_q;
        out_code   = code_q;
        out_valid  = valid_q;
        out_last   = valid_q && (cnt_q == LAST);
    end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Self-checking bench: table-driven vectors for HOLD = 4, hand sequences for
// async reset mid-strobe, and a HOLD = 1 streaming sweep.
module tb_onehot_decoder_seq;
    import onehot_decoder_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [2:0] in_code;
    logic [7:0] out_onehot;
    logic       out_valid, out_last;
    logic [2:0] out_code;

    logic       in_valid_h1, in_ready_h1;
    logic [2:0] in_code_h1;
    logic [7:0] out_onehot_h1;
    logic       out_valid_h1, out_last_h1;
    logic [2:0] out_code_h1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    onehot_decoder_seq #(.CODE_W(3), .HOLD(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .out_onehot (out_onehot),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_code   (out_code)
    );

    onehot_decoder_seq #(.CODE_W(3), .HOLD(1)) dut_h1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid_h1),
        .in_ready   (in_ready_h1),
        .in_code    (in_code_h1),
        .out_onehot (out_onehot_h1),
        .out_valid  (out_valid_h1),
        .out_last   (out_last_h1),
        .out_code   (out_code_h1)
    );

    typedef struct {
        string      name;
        logic       vld;
        logic [2:0] code;
        logic [7:0] exp_oh;
        logic       exp_valid;
        logic       exp_last;
        logic [2:0] exp_code;
        logic       exp_ready;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input string name, input logic vld, input logic [2:0] code,
                          input logic [7:0] oh, input logic v, input logic l,
                          input logic [2:0] c, input logic r);
        vec_t e;
        e.name = name; e.vld = vld; e.code = code;
        e.exp_oh = oh; e.exp_valid = v; e.exp_last = l; e.exp_code = c; e.exp_ready = r;
        vecs.push_back(e);
    endtask

    // Compare one bundle {onehot, valid, last, code, ready} against its expectation.
    task automatic checkOutput(input string name, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got oh=%h v=%b l=%b code=%0d rdy=%b, need oh=%h v=%b l=%b code=%0d rdy=%b",
                     name, act[13:6], act[5], act[4], act[3:1], act[0],
                     exp[13:6], exp[5], exp[4], exp[3:1], exp[0]);
        end
    endtask

    task automatic checkMain(input string name, input logic [7:0] oh, input logic v,
                             input logic l, input logic [2:0] c, input logic r);
        checkOutput(name, {out_onehot, out_valid, out_last, out_code, in_ready}, {oh, v, l, c, r});
    endtask

    task automatic checkH1(input string name, input logic [7:0] oh, input logic v,
                           input logic l, input logic [2:0] c, input logic r);
        checkOutput(name, {out_onehot_h1, out_valid_h1, out_last_h1, out_code_h1, in_ready_h1},
                    {oh, v, l, c, r});
    endtask

    // Present inputs for the next rising edge, then settle just after it.
    task automatic applyStimulus(input logic vld, input logic [2:0] code);
        in_valid = vld;
        in_code  = code;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_code     = '0;
        in_valid_h1 = 1'b0;
        in_code_h1  = '0;

        repeat (3) @(posedge clk);
        #1;
        checkMain("reset_hold", 8'h00, 0, 0, 3'd0, 0);
        checkH1("reset_hold_h1", 8'h00, 0, 0, 3'd0, 0);
        rst_n = 1'b1;
        #1;
        checkMain("reset_release", 8'h00, 0, 0, 3'd0, 1);

        for (int i = 0; i < 10; i++) addVec("idle", 0, 3'd0, 8'h00, 0, 0, 3'd0, 1);
        // single code 5
        addVec("single_c1", 1, 3'd5, 8'h20, 1, 0, 3'd5, 0);
        addVec("single_c2", 0, 3'd0, 8'h20, 1, 0, 3'd5, 0);
        addVec("single_c3", 0, 3'd0, 8'h20, 1, 0, 3'd5, 0);
        addVec("single_c4", 0, 3'd0, 8'h20, 1, 1, 3'd5, 1);
        addVec("single_end", 0, 3'd0, 8'h00, 0, 0, 3'd0, 1);
        // back-to-back 0 then 7
        addVec("b2b_a1", 1, 3'd0, 8'h01, 1, 0, 3'd0, 0);
        addVec("b2b_a2", 1, 3'd7, 8'h01, 1, 0, 3'd0, 0);
        addVec("b2b_a3", 1, 3'd7, 8'h01, 1, 0, 3'd0, 0);
        addVec("b2b_a4", 1, 3'd7, 8'h01, 1, 1, 3'd0, 1);
        addVec("b2b_b1", 1, 3'd7, 8'h80, 1, 0, 3'd7, 0);
        addVec("b2b_b2", 0, 3'd0, 8'h80, 1, 0, 3'd7, 0);
        addVec("b2b_b3", 0, 3'd0, 8'h80, 1, 0, 3'd7, 0);
        addVec("b2b_b4", 0, 3'd0, 8'h80, 1, 1, 3'd7, 1);
        addVec("b2b_end", 0, 3'd0, 8'h00, 0, 0, 3'd0, 1);
        // back-pressure: code 1, then toggling 2/3 while not ready
        addVec("bp_c1", 1, 3'd1, 8'h02, 1, 0, 3'd1, 0);
        addVec("bp_c2", 1, 3'd2, 8'h02, 1, 0, 3'd1, 0);
        addVec("bp_c3", 1, 3'd3, 8'h02, 1, 0, 3'd1, 0);
        addVec("bp_c4", 1, 3'd2, 8'h02, 1, 1, 3'd1, 1);
        addVec("bp_next1", 1, 3'd3, 8'h08, 1, 0, 3'd3, 0);
        addVec("bp_next2", 0, 3'd0, 8'h08, 1, 0, 3'd3, 0);
        addVec("bp_next3", 0, 3'd0, 8'h08, 1, 0, 3'd3, 0);
        addVec("bp_next4", 0, 3'd0, 8'h08, 1, 1, 3'd3, 1);
        addVec("bp_end", 0, 3'd0, 8'h00, 0, 0, 3'd0, 1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].vld, vecs[i].code);
            checkMain(vecs[i].name, vecs[i].exp_oh, vecs[i].exp_valid, vecs[i].exp_last,
                      vecs[i].exp_code, vecs[i].exp_ready);
        end

        // async reset in DRIVE cycle 2
        applyStimulus(1, 3'd6);
        checkMain("ar_c1", 8'h40, 1, 0, 3'd6, 0);
        applyStimulus(0, 3'd0);
        checkMain("ar_c2", 8'h40, 1, 0, 3'd6, 0);
        #3 rst_n = 1'b0;
        #1;
        checkMain("ar_asserted", 8'h00, 0, 0, 3'd0, 0);
        #1 rst_n = 1'b1;
        #1;
        checkMain("ar_released", 8'h00, 0, 0, 3'd0, 1);
        applyStimulus(0, 3'd0);
        checkMain("ar_idle", 8'h00, 0, 0, 3'd0, 1);
        applyStimulus(1, 3'd4);
        checkMain("ar_reload", 8'h10, 1, 0, 3'd4, 0);
        repeat (4) applyStimulus(0, 3'd0);
        checkMain("ar_reload_end", 8'h00, 0, 0, 3'd0, 1);

        // HOLD = 1 streaming sweep
        checkH1("h1_idle", 8'h00, 0, 0, 3'd0, 1);
        in_valid_h1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_code_h1 = 3'(k);
            @(posedge clk);
            #1;
            checkH1($sformatf("h1_sweep_%0d", k), onehot_of(3'(k)), 1, 1, 3'(k), 1);
        end
        in_valid_h1 = 1'b0;
        @(posedge clk);
        #1;
        checkH1("h1_end", 8'h00, 0, 0, 3'd0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
